// File: rtl/pulse_burst_counter_pkg.sv
// Shared definitions for the pulse counter blocks: FSM encoding and default timing constants.
package pulse_burst_counter_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StArmed    = 2'd1,
    StCounting = 2'd2,
    StDone     = 2'd3
  } burst_state_e;

  localparam int unsigned DefaultIdleCycles = 8;
  localparam int unsigned TimerWidth        = 8;

endpackage

// File: rtl/pin_edge_detect.sv
// Two-flop synchroniser followed by a delay flop; rise pulses for one cycle per rising edge of din.
module pin_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic sync1_q, sync2_q, dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign rise = sync2_q & ~dly_q;

endmodule

// File: rtl/pulse_burst_counter.sv
// Counts rising edges on an asynchronous pin during a burst; a burst ends after IDLE_CYCLES quiet cycles.
module pulse_burst_counter
  import pulse_burst_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned IDLE_CYCLES = DefaultIdleCycles,
  parameter int unsigned EXPECT      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             pin,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             match
);

  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(IDLE_CYCLES - 1);
  localparam logic [WIDTH-1:0]      CntMax    = '1;
  localparam logic [WIDTH-1:0]      ExpectVal = WIDTH'(EXPECT);
  // An EXPECT that does not fit in WIDTH bits can never match.
  localparam bit                    ExpectFits = ((EXPECT >> WIDTH) == 0);

  logic                  rise;
  burst_state_e          state_q, state_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic                  ovf_q, ovf_d;
  logic                  valid_q;
  logic [WIDTH-1:0]      count_q;
  logic                  overflow_q, match_q;

  pin_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (pin),
    .rise  (rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    ovf_d   = ovf_q;
    if (arm) begin
      // arm wins over a coincident rise, which is dropped
      state_d = StArmed;
      cnt_d   = '0;
      timer_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StArmed: begin
          if (rise) begin
            cnt_d   = WIDTH'(1);
            timer_d = '0;
            ovf_d   = 1'b0;
            state_d = StCounting;
          end
        end
        StCounting: begin
          if (rise) begin
            if (cnt_q == CntMax) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimerWidth'(1);
            if (timer_q == TimerLast) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      timer_q    <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      valid_q <= (state_q == StDone);
      // Results are latched from the held burst values while in DONE, so arm cannot disturb them.
      if (state_q == StDone) begin
        count_q    <= cnt_q;
        overflow_q <= ovf_q;
        match_q    <= ExpectFits && (cnt_q == ExpectVal) && !ovf_q;
      end
    end
  end

  assign busy     = (state_q == StArmed) || (state_q == StCounting);
  assign valid    = valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign match    = match_q;

endmodule

// File: tb/tb_pulse_burst_counter.sv
// Directed bench: a 16-bit and a 3-bit counter share stimulus; table-driven bursts plus corner sequences.
module tb_pulse_burst_counter;

  localparam int unsigned Idle = 8;

  logic        clk = 1'b0;
  logic        reset, arm, pin;
  logic        busy, valid, overflow, match;
  logic [15:0] count;
  logic        busy3, valid3, overflow3, match3;
  logic [2:0]  count3;

  int total = 0;
  int bad   = 0;
  int nvalid = 0;
  int nvalid3 = 0;

  typedef struct {
    int pulses;
    int cnt;
    bit mt;
    bit ov;
    int cnt3;
    bit mt3;
    bit ov3;
  } vec_t;

  vec_t vecs[6];

  pulse_burst_counter #(.WIDTH(16), .IDLE_CYCLES(Idle), .EXPECT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .arm      (arm),
    .pin      (pin),
    .busy     (busy),
    .valid    (valid),
    .count    (count),
    .overflow (overflow),
    .match    (match)
  );

  pulse_burst_counter #(.WIDTH(3), .IDLE_CYCLES(Idle), .EXPECT(4)) dut3 (
    .clk      (clk),
    .reset    (reset),
    .arm      (arm),
    .pin      (pin),
    .busy     (busy3),
    .valid    (valid3),
    .count    (count3),
    .overflow (overflow3),
    .match    (match3)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) nvalid++;
    if (valid3 === 1'b1) nvalid3++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse();
    pin = 1'b1;
    tick();
    tick();
    pin = 1'b0;
    tick();
    tick();
  endtask

  task automatic arm_once();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (valid !== 1'b1 && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  int lat, nv0, nv30;

  initial begin
    vecs[0] = '{pulses: 4,  cnt: 4,  mt: 1, ov: 0, cnt3: 4, mt3: 1, ov3: 0};
    vecs[1] = '{pulses: 7,  cnt: 7,  mt: 0, ov: 0, cnt3: 7, mt3: 0, ov3: 0};
    vecs[2] = '{pulses: 10, cnt: 10, mt: 0, ov: 0, cnt3: 7, mt3: 0, ov3: 1};
    vecs[3] = '{pulses: 8,  cnt: 8,  mt: 0, ov: 0, cnt3: 7, mt3: 0, ov3: 1};
    vecs[4] = '{pulses: 1,  cnt: 1,  mt: 0, ov: 0, cnt3: 1, mt3: 0, ov3: 0};
    vecs[5] = '{pulses: 3,  cnt: 3,  mt: 0, ov: 0, cnt3: 3, mt3: 0, ov3: 0};

    reset = 1'b1;
    arm   = 1'b0;
    pin   = 1'b0;
    repeat (3) tick();
    chk("reset busy", 32'(busy), 0);
    chk("reset valid", 32'(valid), 0);
    chk("reset count", 32'(count), 0);
    chk("reset overflow", 32'(overflow), 0);
    chk("reset match", 32'(match), 0);
    reset = 1'b0;
    tick();

    // Edges while idle are ignored.
    nv0 = nvalid;
    repeat (3) pulse();
    repeat (15) tick();
    chk("idle ignore busy", 32'(busy), 0);
    chk("idle ignore valid count", 32'(nvalid - nv0), 0);

    for (int i = 0; i < 6; i++) begin
      nv0  = nvalid;
      nv30 = nvalid3;
      arm_once();
      chk($sformatf("v%0d busy armed", i), 32'(busy), 1);
      for (int p = 0; p < vecs[i].pulses; p++) pulse();
      chk($sformatf("v%0d busy counting", i), 32'(busy), 1);
      wait_valid(40, lat);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(Idle));
      chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d match", i), 32'(match), 32'(vecs[i].mt));
      chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].ov));
      chk($sformatf("v%0d valid3", i), 32'(valid3), 1);
      chk($sformatf("v%0d count3", i), 32'(count3), 32'(vecs[i].cnt3));
      chk($sformatf("v%0d match3", i), 32'(match3), 32'(vecs[i].mt3));
      chk($sformatf("v%0d overflow3", i), 32'(overflow3), 32'(vecs[i].ov3));
      chk($sformatf("v%0d busy done", i), 32'(busy), 0);
      tick();
      tick();
      chk($sformatf("v%0d valid low", i), 32'(valid), 0);
      chk($sformatf("v%0d valid strobes", i), 32'(nvalid - nv0), 1);
      chk($sformatf("v%0d valid3 strobes", i), 32'(nvalid3 - nv30), 1);
    end

    // Re-arming mid-burst restarts the count.
    nv0 = nvalid;
    arm_once();
    repeat (3) pulse();
    arm_once();
    repeat (2) pulse();
    wait_valid(40, lat);
    chk("rearm latency", 32'(lat), 32'(Idle));
    chk("rearm count", 32'(count), 2);
    tick();
    tick();
    chk("rearm single valid", 32'(nvalid - nv0), 1);

    // Edges while arm is held are discarded; arm leaves the latched results alone.
    nv0 = nvalid;
    arm = 1'b1;
    repeat (3) pulse();
    repeat (4) tick();
    chk("arm held busy", 32'(busy), 1);
    chk("arm held count kept", 32'(count), 2);
    arm = 1'b0;
    tick();
    repeat (5) pulse();
    wait_valid(40, lat);
    chk("arm held latency", 32'(lat), 32'(Idle));
    chk("arm held count", 32'(count), 5);
    tick();
    chk("arm held single valid", 32'(nvalid - nv0), 1);

    // A pin that is already high produces no rise.
    nv0 = nvalid;
    pin = 1'b1;
    repeat (4) tick();
    arm_once();
    repeat (20) tick();
    pin = 1'b0;
    repeat (20) tick();
    chk("steady pin busy", 32'(busy), 1);
    chk("steady pin no valid", 32'(nvalid - nv0), 0);
    chk("steady pin count kept", 32'(count), 5);

    // Reset mid-burst abandons it; later edges need a fresh arm.
    nv0 = nvalid;
    arm_once();
    repeat (2) pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid reset busy", 32'(busy), 0);
    chk("mid reset count", 32'(count), 0);
    repeat (2) pulse();
    repeat (20) tick();
    chk("post reset no valid", 32'(nvalid - nv0), 0);
    chk("post reset busy", 32'(busy), 0);
    chk("post reset count", 32'(count), 0);
    chk("post reset overflow", 32'(overflow), 0);
    chk("post reset match", 32'(match), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
